// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for the DIV/DIVU execute path.
// Produces {remainder, quotient} one quotient bit per cycle, with a registered ready flag.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic [31:0] mag1, mag2;
  logic [32:0] partial;
  logic        sub_ok;
  logic [31:0] rem_sub;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes: the core always divides unsigned, signs are restored at the end.
  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // 33-bit partial remainder: shifted remainder plus the next dividend bit.
  assign partial = {rem_q, quo_q[31]};
  assign sub_ok  = (partial >= {1'b0, divisor_q});
  // When the subtraction succeeds the difference is below the divisor, so 32 bits suffice.
  assign rem_sub = partial[31:0] - divisor_q;

  assign quo_fix = (sign_q && (neg1_q ^ neg2_q)) ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = (sign_q && neg1_q) ? (~rem_q + 32'd1) : rem_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    ready_d   = ready_q;
    result_d  = result_q;

    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = 6'd0;
            sign_d    = signed_div_i;
            neg1_d    = opdata1_i[31];
            neg2_d    = opdata2_i[31];
            quo_d     = mag1;
            divisor_d = mag2;
            rem_d     = 32'd0;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = 64'd0;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q != 6'd32) begin
          rem_d = sub_ok ? rem_sub : partial[31:0];
          quo_d = {quo_q[30:0], sub_ok};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end

      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end

      default: state_d = S_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      sign_q    <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      divisor_q <= 32'd0;
      ready_q   <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues expected results from an arithmetic model,
// a monitor pops and compares each time ready_o rises.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_r;
  logic [31:0] op1_r, op2_r;
  logic        start_r;
  logic        annul_r;
  logic        hs_mode;
  logic        start_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests;
  int n_fail;
  logic [63:0] exp_q[$];

  assign start_i = hs_mode ? !ready_o : start_r;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_r),
    .opdata1_i    (op1_r),
    .opdata2_i    (op2_r),
    .start_i      (start_i),
    .annul_i      (annul_r),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit arithmetic truncated to 32 bits.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (!sg) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: compare on each rising ready_o; outside ready the result must read zero.
  logic mon_prev;
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 1'b0;
        continue;
      end
      if (ready_o && !mon_prev) begin
        if (exp_q.size() == 0) check("spurious_ready", 64'(ready_o), 64'd0);
        else check("result", result_o, exp_q.pop_front());
      end else if (!ready_o) begin
        check("idle_result_zero", result_o, 64'd0);
      end
      mon_prev = ready_o;
    end
  end

  // Called at posedge+1 with the block in FREE.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    int cyc;
    logic [63:0] exp;
    exp = model(sg, a, b);
    signed_r = sg;
    op1_r    = a;
    op2_r    = b;
    start_r  = 1'b1;
    exp_q.push_back(exp);
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'((b == 32'd0) ? 2 : 34));
    for (int i = 0; i < hold; i++) begin
      op1_r    = $urandom;
      op2_r    = $urandom;
      signed_r = ~signed_r;
      @(posedge clk); #1;
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_r = 1'b0;
    @(posedge clk); #1;
    check("release_ready", 64'(ready_o), 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, falls, highs, idx;
    logic prev;
    logic [31:0] hs_a [3];
    logic [31:0] hs_b [3];
    logic        hs_s [3];
    logic        sg;
    logic [31:0] a, b;

    n_tests  = 0;
    n_fail   = 0;
    hs_mode  = 1'b0;
    rst      = 1'b1;
    signed_r = 1'b0;
    op1_r    = 32'd10;
    op2_r    = 32'd5;
    start_r  = 1'b1;
    annul_r  = 1'b0;

    // Reset holds the block idle even with start asserted.
    #3;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_ready", 64'(ready_o), 64'd0);
    start_r = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_div(1'b0, 32'd1234, 32'd0, 3);
    run_div(1'b1, 32'hFFFFFF85, 32'd13, 2);

    // Annul at cnt=10: the division is dropped and ready never rises.
    signed_r = 1'b0;
    op1_r    = 32'd1000;
    op2_r    = 32'd3;
    start_r  = 1'b1;
    repeat (11) begin
      @(posedge clk); #1;
    end
    annul_r = 1'b1;
    start_r = 1'b0;
    @(posedge clk); #1;
    annul_r = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("annul_no_ready", 64'(ready_o), 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);

    // Asynchronous reset at cnt=20.
    signed_r = 1'b0;
    op1_r    = 32'd500;
    op2_r    = 32'd7;
    start_r  = 1'b1;
    repeat (21) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_on_ready", 64'(ready_o), 64'd0);
    check("arst_on_result", result_o, 64'd0);
    start_r = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset while holding a completed result.
    signed_r = 1'b0;
    op1_r    = 32'd100;
    op2_r    = 32'd7;
    start_r  = 1'b1;
    exp_q.push_back(model(1'b0, 32'd100, 32'd7));
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("arst_end_latency", 64'(cyc), 64'd34);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("arst_end_ready", 64'(ready_o), 64'd0);
    check("arst_end_result", result_o, 64'd0);
    start_r = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized divisions
    for (int n = 0; n < 24; n++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(sg, a, b, $urandom_range(0, 2));
    end

    // Execute-stage handshake: start_i = !ready_o, three back-to-back divisions.
    hs_a = '{32'd1000, 32'hFFFFFF00, 32'd12345};
    hs_b = '{32'd10, 32'd16, 32'd123};
    hs_s = '{1'b0, 1'b1, 1'b0};
    idx = 0;
    signed_r = hs_s[0];
    op1_r    = hs_a[0];
    op2_r    = hs_b[0];
    exp_q.push_back(model(hs_s[0], hs_a[0], hs_b[0]));
    hs_mode = 1'b1;
    cyc = 0; falls = 0; highs = 0;
    while (falls < 3 && cyc < 400) begin
      prev = ready_o;
      @(posedge clk); #1;
      cyc++;
      if (ready_o) begin
        highs++;
        if (!prev && idx < 2) begin
          idx++;
          signed_r = hs_s[idx];
          op1_r    = hs_a[idx];
          op2_r    = hs_b[idx];
          exp_q.push_back(model(hs_s[idx], hs_a[idx], hs_b[idx]));
        end
      end
      if (prev && !ready_o) falls++;
    end
    hs_mode = 1'b0;
    start_r = 1'b0;
    check("hs_total_cycles", 64'(cyc), 64'd105);
    check("hs_ready_cycles", 64'(highs), 64'd3);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
